channel_out_buf: RTL
====================

CHANNEL_OUT_BUF -- requirements
Module: channel_out_buf

Interface
REQ-001 Parameter DEPTH, default 128, byte capacity of the packet buffer; SHALL be a power of two and at least 65.
REQ-002 clock  input  1  single clock for all logic; all registers SHALL update on its rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-low.
REQ-004 in_valid  input  1  upstream router byte valid.
REQ-005 in_data  input  8  upstream byte (YAPP header, payload or parity).
REQ-006 in_last  input  1  marks the final byte (parity) of a packet.
REQ-007 in_ready  output  1  buffer can accept a byte.
REQ-008 data_vld  output  1  channel byte valid.
REQ-009 data  output  8  channel byte.
REQ-010 suspend  input  1  channel backpressure; high means no byte is consumed this cycle.
REQ-011 pkt_count  output  16  packets fully delivered on the channel; present only with CHANNEL_OUT_BUF_STATS_EN.

Function
REQ-012 An input write SHALL occur on a rising edge where in_valid=1 and in_ready=1; bytes with in_ready=0 are not stored, and upstream holds them.
REQ-013 in_ready SHALL be 1 exactly when the stored byte count is below DEPTH, decoded from registered state only.
REQ-014 The block SHALL be store-and-forward: a packet is sent only after its in_last byte has been written.
REQ-015 The block SHALL keep a registered count of complete packets: +1 on a write with in_last=1, -1 on a channel transfer of a last byte, and unchanged when both occur on the same edge.
REQ-016 A channel transfer SHALL occur on a rising edge where data_vld=1 and suspend=0; the head byte is popped on that edge.
REQ-017 The FSM SHALL have three states: IDLE, SEND and GAP.
REQ-018 In IDLE, data_vld=0; the FSM SHALL go to SEND on the edge where the complete-packet count is nonzero.
REQ-019 In SEND, data_vld=1 and data=buffer head. data and data_vld SHALL hold stable while suspend=1.
REQ-020 In SEND, on a transfer of a last byte the FSM SHALL go to GAP; otherwise it stays in SEND.
REQ-021 In GAP, data_vld=0 for exactly one cycle; the FSM then goes to IDLE, or directly to SEND if the complete-packet count is nonzero.
REQ-022 Latency: last byte written at edge N gives data_vld=1 in the cycle after edge N+1 (FSM in IDLE, no suspend).
REQ-023 Reads and writes SHALL be allowed on the same edge; the byte count SHALL then remain unchanged.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH with no lost or duplicated byte.
REQ-025 A packet longer than DEPTH bytes is an upstream protocol violation; behaviour is undefined.
REQ-026 suspend SHALL be ignored in IDLE and GAP.

Reset
REQ-027 Asserting reset SHALL immediately clear pointers, byte count and packet count, set FSM=IDLE, data_vld=0, data=8'h00, in_ready=1 and pkt_count=0.
REQ-028 Reset mid-packet SHALL discard all buffered bytes, including partial packets; after release, the first accepted byte is treated as a header.

Configuration
REQ-029 Macro CHANNEL_OUT_BUF_STATS_EN defined: pkt_count SHALL increment by 1 on each transfer of a last byte and wrap from 16'hFFFF to 0.
REQ-030 Macro CHANNEL_OUT_BUF_STATS_EN undefined: the pkt_count port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Single packet: write header 8'h0C, 3 payload bytes, parity with in_last, suspend=0 -> data_vld high 5 consecutive cycles, bytes in order, then 1 low cycle; pkt_count=1.
REQ-032 Suspend: assert suspend for 4 cycles during the 2nd byte -> data holds the 2nd byte, data_vld stays 1 and no byte is lost; the packet takes 9 data_vld cycles.
REQ-033 Back-to-back: two 4-byte packets written before the first is sent -> exactly one data_vld=0 cycle between the packets.
REQ-034 Full: suspend=1 while writing 128 bytes -> in_ready=0 after the 128th write; releasing suspend pops a byte and in_ready returns to 1 the next cycle.
REQ-035 Simultaneous: write the last byte of packet B on the same edge as the transfer of A's last byte -> the packet count stays 1 and B is sent after the GAP cycle.
REQ-036 Reset mid-packet: assert reset during the 3rd byte of a packet -> data_vld=0 and in_ready=1 immediately; no stale byte appears after the next packet is written.

Source files
------------

// File: rtl/channel_out_buf.sv
// Store-and-forward channel output buffer: holds router bytes until a full packet is present, then streams it.
// Optional delivered-packet counter on pkt_count when CHANNEL_OUT_BUF_STATS_EN is defined.
module channel_out_buf #(
  parameter int DEPTH = 128
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       data_vld,
  output logic [7:0] data,
  input  logic       suspend
`ifdef CHANNEL_OUT_BUF_STATS_EN
  ,
  output logic [15:0] pkt_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAPACITY = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Each entry carries the byte plus its end-of-packet flag.
  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_byteCount;
  logic [AW:0]   r_pktPending;

  logic [8:0] w_head;
  logic       w_write;
  logic       w_xfer;
  logic       w_headLast;
  logic       w_pktIn;
  logic       w_pktOut;

  assign w_head     = r_mem[r_rdPtr];
  assign w_headLast = w_head[8];
  assign in_ready   = (r_byteCount < CAPACITY);
  assign w_write    = in_valid & in_ready;
  assign data_vld   = (r_state == SEND);
  assign data       = data_vld ? w_head[7:0] : 8'h00;
  assign w_xfer     = data_vld & ~suspend;
  assign w_pktIn    = w_write & in_last;
  assign w_pktOut   = w_xfer & w_headLast;

  always_ff @(posedge clock) begin
    if (w_write) begin
      r_mem[r_wrPtr] <= {in_last, in_data};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_byteCount  <= '0;
      r_pktPending <= '0;
    end else begin
      if (w_write) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_xfer) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_write, w_xfer})
        2'b10:   r_byteCount <= r_byteCount + 1'b1;
        2'b01:   r_byteCount <= r_byteCount - 1'b1;
        default: r_byteCount <= r_byteCount;
      endcase
      case ({w_pktIn, w_pktOut})
        2'b10:   r_pktPending <= r_pktPending + 1'b1;
        2'b01:   r_pktPending <= r_pktPending - 1'b1;
        default: r_pktPending <= r_pktPending;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // GAP forces one idle channel cycle between packets.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (r_pktPending != '0) begin
          w_nextState = SEND;
        end
      end
      SEND: begin
        if (w_xfer && w_headLast) begin
          w_nextState = GAP;
        end
      end
      GAP: begin
        w_nextState = (r_pktPending != '0) ? SEND : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

`ifdef CHANNEL_OUT_BUF_STATS_EN
  logic [15:0] r_pktCount;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pktCount <= 16'h0000;
    end else if (w_pktOut) begin
      r_pktCount <= r_pktCount + 16'd1;
    end
  end

  assign pkt_count = r_pktCount;
`endif

endmodule
